// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite register-file responder: response codes,
// FSM state encodings and default geometry.
package axi4_lite_pkg;

    localparam int unsigned ADDR_W_DEF   = 8;
    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned NUM_REGS_DEF = 16;
    localparam logic [31:0] ID_VALUE_DEF = 32'hA11E_0001;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        WR_IDLE,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_t;

    function automatic resp_t hit_to_resp(input logic hit);
        return hit ? OKAY : SLVERR;
    endfunction

endpackage

// File: rtl/axi4_lite_reg_bank.sv
// Word register storage with strobe-merge write port, read mux, read-only ID
// word at index 0 and a per-port decode hit.
module axi4_lite_reg_bank
    import axi4_lite_pkg::*;
#(
    parameter  int unsigned ADDR_W   = ADDR_W_DEF,
    parameter  int unsigned DATA_W   = DATA_W_DEF,
    parameter  int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter  logic [31:0] ID_VALUE = ID_VALUE_DEF,
    localparam int unsigned STRB_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [STRB_W-1:0] wr_strb,
    output logic              wr_hit_c,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data_c,
    output logic              rd_hit_c
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);
    localparam int unsigned LIMIT = NUM_REGS * 4;

    logic [DATA_W-1:0] mem [NUM_REGS];
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              wr_in_range;

    assign wr_idx      = wr_addr[IDX_W+1:2];
    assign rd_idx      = rd_addr[IDX_W+1:2];
    assign wr_in_range = 32'(wr_addr) < LIMIT;
    assign rd_hit_c    = 32'(rd_addr) < LIMIT;

    // Index 0 is the ID word, so it is never a write target.
    assign wr_hit_c = wr_in_range && (wr_idx != '0);

    always_comb begin
        rd_data_c = '0;
        if (rd_hit_c) begin
            if (rd_idx == '0) begin
                rd_data_c = DATA_W'(ID_VALUE);
            end else begin
                rd_data_c = mem[rd_idx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && wr_hit_c) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite responder over a small register bank: independent write and read
// FSMs, AW/W accepted in any order, registered handshake outputs.
module axi4_lite_regfile_slave
    import axi4_lite_pkg::*;
#(
    parameter  int unsigned ADDR_W   = ADDR_W_DEF,
    parameter  int unsigned DATA_W   = DATA_W_DEF,
    parameter  int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter  logic [31:0] ID_VALUE = ID_VALUE_DEF,
    localparam int unsigned STRB_W   = DATA_W / 8
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [STRB_W-1:0] WSTRB,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RVALID,
    input  logic              RREADY
);

    wr_state_t         wr_state;
    rd_state_t         rd_state;
    logic              aw_held;
    logic              w_held;
    logic [ADDR_W-1:0] aw_addr;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;

    logic              aw_fire;
    logic              w_fire;
    logic              ar_fire;
    logic              wr_commit;
    logic [ADDR_W-1:0] wr_addr_mux;
    logic [DATA_W-1:0] wr_data_mux;
    logic [STRB_W-1:0] wr_strb_mux;
    logic              wr_hit_c;
    logic              rd_hit_c;
    logic [DATA_W-1:0] rd_data_c;

    assign aw_fire = AWVALID && AWREADY;
    assign w_fire  = WVALID && WREADY;
    assign ar_fire = ARVALID && ARREADY;

    // A channel accepted earlier comes from its latch, otherwise straight from the bus.
    assign wr_addr_mux = aw_held ? aw_addr : AWADDR;
    assign wr_data_mux = w_held  ? w_data  : WDATA;
    assign wr_strb_mux = w_held  ? w_strb  : WSTRB;
    assign wr_commit   = (wr_state == WR_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);

    axi4_lite_reg_bank #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ID_VALUE(ID_VALUE)
    ) u_bank (
        .clk      (ACLK),
        .rst      (ARESET),
        .wr_en    (wr_commit),
        .wr_addr  (wr_addr_mux),
        .wr_data  (wr_data_mux),
        .wr_strb  (wr_strb_mux),
        .wr_hit_c (wr_hit_c),
        .rd_addr  (ARADDR),
        .rd_data_c(rd_data_c),
        .rd_hit_c (rd_hit_c)
    );

    // Write path: collect AW and W, commit once both are present, hold B until taken.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state <= WR_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_addr  <= '0;
            w_data   <= '0;
            w_strb   <= '0;
            AWREADY  <= 1'b0;
            WREADY   <= 1'b0;
            BVALID   <= 1'b0;
            BRESP    <= 2'b00;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (aw_fire) begin
                        aw_held <= 1'b1;
                        aw_addr <= AWADDR;
                    end
                    if (w_fire) begin
                        w_held <= 1'b1;
                        w_data <= WDATA;
                        w_strb <= WSTRB;
                    end
                    if (wr_commit) begin
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                        AWREADY  <= 1'b0;
                        WREADY   <= 1'b0;
                        BVALID   <= 1'b1;
                        BRESP    <= 2'(hit_to_resp(wr_hit_c));
                        wr_state <= WR_RESP;
                    end else begin
                        AWREADY <= !(aw_held || aw_fire);
                        WREADY  <= !(w_held || w_fire);
                    end
                end
                WR_RESP: begin
                    if (BREADY) begin
                        BVALID   <= 1'b0;
                        AWREADY  <= 1'b1;
                        WREADY   <= 1'b1;
                        wr_state <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    // Read path: one-cycle lookup, RDATA/RRESP held until RREADY and kept afterwards.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_state <= RD_IDLE;
            ARREADY  <= 1'b0;
            RVALID   <= 1'b0;
            RDATA    <= '0;
            RRESP    <= 2'b00;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_fire) begin
                        RDATA    <= rd_data_c;
                        RRESP    <= 2'(hit_to_resp(rd_hit_c));
                        RVALID   <= 1'b1;
                        ARREADY  <= 1'b0;
                        rd_state <= RD_DATA;
                    end else begin
                        ARREADY <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (RREADY) begin
                        RVALID   <= 1'b0;
                        ARREADY  <= 1'b1;
                        rd_state <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Directed self-checking bench for axi4_lite_regfile_slave.
module tb_axi4_lite_regfile_slave;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [7:0]  AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [7:0]  ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    int total = 0;
    int bad   = 0;

    always #5 ACLK = ~ACLK;

    axi4_lite_regfile_slave dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .AWADDR (AWADDR),
        .AWVALID(AWVALID),
        .AWREADY(AWREADY),
        .WDATA  (WDATA),
        .WSTRB  (WSTRB),
        .WVALID (WVALID),
        .WREADY (WREADY),
        .BRESP  (BRESP),
        .BVALID (BVALID),
        .BREADY (BREADY),
        .ARADDR (ARADDR),
        .ARVALID(ARVALID),
        .ARREADY(ARREADY),
        .RDATA  (RDATA),
        .RRESP  (RRESP),
        .RVALID (RVALID),
        .RREADY (RREADY)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic write_same(input logic [7:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [1:0] exp_resp,
                              input string tag);
        AWADDR = addr; WDATA = data; WSTRB = strb;
        AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        check({tag, "_b"}, {62'd0, BVALID, AWREADY | WREADY}, 64'h2);
        check({tag, "_bresp"}, 64'(BRESP), 64'(exp_resp));
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        check({tag, "_bdone"}, {61'd0, BVALID, AWREADY, WREADY}, 64'h3);
    endtask

    task automatic read_chk(input logic [7:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input string tag);
        ARADDR = addr; ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
        check({tag, "_r"}, {30'd0, RVALID, ARREADY, RRESP, RDATA}, {30'd0, 1'b1, 1'b0, exp_resp, exp_data});
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        check({tag, "_rdone"}, {62'd0, RVALID, ARREADY}, 64'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESET = 1'b1;
        AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
        BREADY = 1'b0; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;

        // Reset held for three edges, then released.
        repeat (3) tick();
        check("rst_outs", {AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RDATA}, 64'd0);
        ARESET = 1'b0;
        tick();
        check("rst_rdy", {61'd0, AWREADY, WREADY, ARREADY}, 64'h7);
        check("rst_valid", {62'd0, BVALID, RVALID}, 64'h0);

        // Aligned AW+W write then readback.
        write_same(8'h04, 32'hDEADBEEF, 4'hF, 2'b00, "wr04");
        read_chk(8'h04, 32'hDEADBEEF, 2'b00, "rd04");

        // Partial strobes and zero strobes.
        write_same(8'h05, 32'h11223344, 4'b0101, 2'b00, "wr04_strb");
        read_chk(8'h04, 32'hDE22BE44, 2'b00, "rd04_strb");
        write_same(8'h04, 32'hFFFFFFFF, 4'h0, 2'b00, "wr04_nostrb");
        read_chk(8'h04, 32'hDE22BE44, 2'b00, "rd04_nostrb");

        // W ahead of AW by three edges, B held back for four cycles.
        WDATA = 32'h000000AA; WSTRB = 4'h1; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        check("wfirst_rdy", {61'd0, AWREADY, WREADY, BVALID}, 64'h4);
        tick();
        tick();
        check("wfirst_wait", {61'd0, AWREADY, WREADY, BVALID}, 64'h4);
        AWADDR = 8'h08; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bhold", {60'd0, BVALID, AWREADY, WREADY, 1'b0} | 64'(BRESP) << 8, 64'h8);
            tick();
        end
        check("bhold_end", {62'd0, BVALID, 1'b0}, 64'h2);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        check("bhold_done", {61'd0, BVALID, AWREADY, WREADY}, 64'h3);
        read_chk(8'h08, 32'h000000AA, 2'b00, "rd08");

        // ID register and out-of-range accesses.
        write_same(8'h00, 32'h55555555, 4'hF, 2'b10, "wr00");
        write_same(8'h40, 32'h55555555, 4'hF, 2'b10, "wr40");
        read_chk(8'h00, 32'hA11E0001, 2'b00, "rd00");
        read_chk(8'h40, 32'h00000000, 2'b10, "rd40");
        read_chk(8'h3F, 32'h00000000, 2'b00, "rd3f");

        // Read and write of the same word on the same edge sees the old value.
        AWADDR = 8'h0C; WDATA = 32'h12345678; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 8'h0C; ARVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        check("same_edge_r", {RVALID, RRESP, RDATA}, {29'd0, 1'b1, 2'b00, 32'h0});
        check("same_edge_b", {61'd0, BVALID, BRESP}, 64'h4);
        BREADY = 1'b1; RREADY = 1'b1;
        tick();
        BREADY = 1'b0; RREADY = 1'b0;
        check("same_edge_done", {62'd0, BVALID, RVALID}, 64'h0);
        check("rdata_hold", 64'(RDATA), 64'h0);
        read_chk(8'h0C, 32'h12345678, 2'b00, "rd0c");

        // Asynchronous reset with B and R both outstanding.
        AWADDR = 8'h10; WDATA = 32'hCAFEF00D; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        ARADDR = 8'h10; ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
        check("pre_rst", {RVALID, BVALID, RDATA}, {30'd0, 2'b11, 32'hCAFEF00D});
        #2;
        ARESET = 1'b1;
        #1;
        check("async_rst", {AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RDATA}, 64'd0);
        tick();
        tick();
        ARESET = 1'b0;
        tick();
        check("rst2_rdy", {61'd0, AWREADY, WREADY, ARREADY}, 64'h7);
        read_chk(8'h10, 32'h00000000, 2'b00, "rd10_cleared");
        read_chk(8'h04, 32'h00000000, 2'b00, "rd04_cleared");
        read_chk(8'h00, 32'hA11E0001, 2'b00, "rd00_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
